// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU sequencing slice.
//   - ALU opcode encodings understood by the sequencer's bench and the alu
//   - bit positions inside the 3-bit {overflow, negative, zero} flag vector
//   - state encoding of the alu_seq control FSM
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001
  } alu_op_e;

  localparam int FLAG_OVF  = 2;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_ZERO = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREG x BW architectural register file.
//   clk, rst_n      : clock and asynchronous active-low reset (clears all entries)
//   ra_addr/ra_data : combinational read port A
//   rb_addr/rb_data : combinational read port B
//   we, wa, wd      : synchronous write port; writes to r0 are dropped
// r0 is hard-wired to zero on both read ports.
module alu_regfile #(
  parameter int BW   = 16,
  parameter int NREG = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [$clog2(NREG)-1:0] ra_addr,
  output logic [BW-1:0]           ra_data,
  input  logic [$clog2(NREG)-1:0] rb_addr,
  output logic [BW-1:0]           rb_data,
  input  logic                    we,
  input  logic [$clog2(NREG)-1:0] wa,
  input  logic [BW-1:0]           wd
);

  logic [BW-1:0] mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  assign ra_data = (ra_addr == '0) ? '0 : mem[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 : mem[rb_addr];

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequencing front-end for the combinational alu.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   instr_valid/instr_ready         : instruction handshake
//   instr_load, instr_opcode        : load-immediate select, ALU opcode
//   instr_rd/ra/rb, instr_imm       : register indices and load immediate
//   alu_in_a/alu_in_b/alu_opcode    : latched operands/opcode driven to the alu
//   alu_out, alu_flags              : alu result and {ovf, neg, zero}
//   result_valid/result_ready       : result handshake
//   result_data, result_flags       : written-back value and flag register
// Each instruction takes IDLE (accept) -> EXEC (alu settles, writeback at its
// end) -> RESP (hold result until the requester takes it).
module alu_seq
  import alu_pkg::*;
#(
  parameter int BW   = 16,
  parameter int NREG = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic                    instr_load,
  input  logic [3:0]              instr_opcode,
  input  logic [$clog2(NREG)-1:0] instr_rd,
  input  logic [$clog2(NREG)-1:0] instr_ra,
  input  logic [$clog2(NREG)-1:0] instr_rb,
  input  logic [BW-1:0]           instr_imm,
  output logic [BW-1:0]           alu_in_a,
  output logic [BW-1:0]           alu_in_b,
  output logic [3:0]              alu_opcode,
  input  logic [BW-1:0]           alu_out,
  input  logic [2:0]              alu_flags,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [BW-1:0]           result_data,
  output logic [2:0]              result_flags
);

  localparam int RW = $clog2(NREG);

  seq_state_e    state;
  logic [RW-1:0] rd_p0;
  logic          load_p0;
  logic [BW-1:0] imm_p0;
  logic [2:0]    flag_reg;

  logic [BW-1:0] rf_a;
  logic [BW-1:0] rf_b;
  logic          wb_en;
  logic [BW-1:0] wb_data;

  // Writeback happens on the edge that leaves EXEC; the alu output is
  // settled by then because the operands were latched one edge earlier.
  assign wb_en   = (state == ST_EXEC);
  assign wb_data = load_p0 ? imm_p0 : alu_out;

  alu_regfile #(
    .BW   (BW),
    .NREG (NREG)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (instr_ra),
    .ra_data (rf_a),
    .rb_addr (instr_rb),
    .rb_data (rf_b),
    .we      (wb_en),
    .wa      (rd_p0),
    .wd      (wb_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      instr_ready  <= 1'b0;
      rd_p0        <= '0;
      load_p0      <= 1'b0;
      imm_p0       <= '0;
      alu_in_a     <= '0;
      alu_in_b     <= '0;
      alu_opcode   <= '0;
      flag_reg     <= '0;
      result_valid <= 1'b0;
      result_data  <= '0;
      result_flags <= '0;
    end else begin
      case (state)
        // Accept stage: capture operand values (not indices) so that a
        // destination equal to a source cannot disturb the operands.
        ST_IDLE: begin
          instr_ready <= 1'b1;
          if (instr_valid && instr_ready) begin
            rd_p0       <= instr_rd;
            load_p0     <= instr_load;
            imm_p0      <= instr_imm;
            alu_in_a    <= rf_a;
            alu_in_b    <= rf_b;
            alu_opcode  <= instr_opcode;
            instr_ready <= 1'b0;
            state       <= ST_EXEC;
          end
        end
        // Capture stage: loads leave the flag register alone but still
        // report it.
        ST_EXEC: begin
          result_data  <= wb_data;
          result_valid <= 1'b1;
          if (load_p0) begin
            result_flags <= flag_reg;
          end else begin
            flag_reg     <= alu_flags;
            result_flags <= alu_flags;
          end
          state <= ST_RESP;
        end
        // Response stage: hold results until the requester takes them.
        ST_RESP: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            instr_ready  <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: begin
          result_valid <= 1'b0;
          instr_ready  <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic        instr_load;
  logic [3:0]  instr_opcode;
  logic [2:0]  instr_rd, instr_ra, instr_rb;
  logic [15:0] instr_imm;
  logic [15:0] alu_in_a, alu_in_b;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_out;
  logic [2:0]  alu_flags;
  logic        result_valid;
  logic        result_ready;
  logic [15:0] result_data;
  logic [2:0]  result_flags;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_seq #(.BW(16), .NREG(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_load   (instr_load),
    .instr_opcode (instr_opcode),
    .instr_rd     (instr_rd),
    .instr_ra     (instr_ra),
    .instr_rb     (instr_rb),
    .instr_imm    (instr_imm),
    .alu_in_a     (alu_in_a),
    .alu_in_b     (alu_in_b),
    .alu_opcode   (alu_opcode),
    .alu_out      (alu_out),
    .alu_flags    (alu_flags),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_data  (result_data),
    .result_flags (result_flags)
  );

  // Stand-in for the external combinational alu: ADD, SUB, others XOR.
  logic [15:0] m_r;
  logic        m_ovf;
  always_comb begin
    m_r   = alu_in_a ^ alu_in_b;
    m_ovf = 1'b0;
    case (alu_opcode)
      4'b0000: begin
        m_r   = alu_in_a + alu_in_b;
        m_ovf = (alu_in_a[15] == alu_in_b[15]) && (m_r[15] != alu_in_a[15]);
      end
      4'b0001: begin
        m_r   = alu_in_a - alu_in_b;
        m_ovf = (alu_in_a[15] != alu_in_b[15]) && (m_r[15] != alu_in_a[15]);
      end
      default: ;
    endcase
    alu_out   = m_r;
    alu_flags = {m_ovf, m_r[15], (m_r == 16'h0000)};
  end

  typedef struct {
    logic        load;
    logic [3:0]  op;
    logic [2:0]  rd, ra, rb;
    logic [15:0] imm;
    logic [15:0] ea, eb;
    logic [15:0] edata;
    logic [2:0]  eflags;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Present an instruction and return one step after the accepting edge.
  task automatic accept(input logic ld, input logic [3:0] op, input logic [2:0] rd,
                        input logic [2:0] ra, input logic [2:0] rb, input logic [15:0] imm);
    bit ok;
    instr_load   = ld;
    instr_opcode = op;
    instr_rd     = rd;
    instr_ra     = ra;
    instr_rb     = rb;
    instr_imm    = imm;
    instr_valid  = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (instr_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=instr_ready_low required=instr_ready_high");
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic do_vec(input int i);
    vec_t v;
    v = vecs[i];
    accept(v.load, v.op, v.rd, v.ra, v.rb, v.imm);
    chk($sformatf("v%0d exec_valid", i), result_valid, 0);
    chk($sformatf("v%0d exec_ready", i), instr_ready, 0);
    chk($sformatf("v%0d alu_in_a", i), alu_in_a, v.ea);
    chk($sformatf("v%0d alu_in_b", i), alu_in_b, v.eb);
    chk($sformatf("v%0d alu_opcode", i), alu_opcode, v.op);
    @(posedge clk); #1;
    chk($sformatf("v%0d result_valid", i), result_valid, 1);
    chk($sformatf("v%0d result_data", i), result_data, v.edata);
    chk($sformatf("v%0d result_flags", i), result_flags, v.eflags);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    chk($sformatf("v%0d done_valid", i), result_valid, 0);
    chk($sformatf("v%0d done_ready", i), instr_ready, 1);
  endtask

  initial begin
    //           load  op     rd    ra    rb    imm       ea        eb        data      flags
    vecs[0]  = '{1'b1, 4'h0, 3'd1, 3'd0, 3'd0, 16'h0002, 16'h0000, 16'h0000, 16'h0002, 3'b000};
    vecs[1]  = '{1'b1, 4'h0, 3'd2, 3'd0, 3'd0, 16'h0002, 16'h0000, 16'h0000, 16'h0002, 3'b000};
    vecs[2]  = '{1'b0, 4'h0, 3'd3, 3'd1, 3'd2, 16'h0000, 16'h0002, 16'h0002, 16'h0004, 3'b000};
    vecs[3]  = '{1'b1, 4'h0, 3'd1, 3'd0, 3'd0, 16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 3'b000};
    vecs[4]  = '{1'b1, 4'h0, 3'd2, 3'd0, 3'd0, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 3'b000};
    vecs[5]  = '{1'b0, 4'h1, 3'd3, 3'd1, 3'd2, 16'h0000, 16'h7FFF, 16'hFFFF, 16'h8000, 3'b110};
    vecs[6]  = '{1'b1, 4'h0, 3'd4, 3'd0, 3'd0, 16'h1234, 16'h0000, 16'h0000, 16'h1234, 3'b110};
    vecs[7]  = '{1'b0, 4'h1, 3'd5, 3'd1, 3'd1, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h0000, 3'b001};
    vecs[8]  = '{1'b0, 4'h0, 3'd0, 3'd1, 3'd1, 16'h0000, 16'h7FFF, 16'h7FFF, 16'hFFFE, 3'b110};
    vecs[9]  = '{1'b0, 4'h0, 3'd6, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b001};
    vecs[10] = '{1'b0, 4'h0, 3'd3, 3'd3, 3'd4, 16'h0000, 16'h8000, 16'h1234, 16'h9234, 3'b010};
    vecs[11] = '{1'b0, 4'h0, 3'd7, 3'd3, 3'd0, 16'h0000, 16'h9234, 16'h0000, 16'h9234, 3'b010};
    vecs[12] = '{1'b0, 4'h5, 3'd1, 3'd1, 3'd4, 16'h0000, 16'h7FFF, 16'h1234, 16'h6DCB, 3'b000};

    // Reset with random inputs.
    rst_n        = 1'b0;
    instr_valid  = 1'b1;
    instr_load   = 1'($urandom);
    instr_opcode = 4'($urandom);
    instr_rd     = 3'($urandom);
    instr_ra     = 3'($urandom);
    instr_rb     = 3'($urandom);
    instr_imm    = 16'($urandom);
    result_ready = 1'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst instr_ready", instr_ready, 0);
    chk("rst result_valid", result_valid, 0);
    chk("rst result_data", result_data, 0);
    chk("rst result_flags", result_flags, 0);
    chk("rst alu_in_a", alu_in_a, 0);
    chk("rst alu_in_b", alu_in_b, 0);
    chk("rst alu_opcode", alu_opcode, 0);
    instr_valid  = 1'b0;
    result_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel ready_before_edge", instr_ready, 0);
    @(posedge clk); #1;
    chk("rel ready_after_edge", instr_ready, 1);

    for (int i = 0; i < 13; i++) begin
      do_vec(i);
    end

    // Backpressure with a queued instruction waiting.
    accept(1'b1, 4'h0, 3'd5, 3'd0, 3'd0, 16'hABCD);
    @(posedge clk); #1;
    chk("bp first_valid", result_valid, 1);
    instr_load   = 1'b0;
    instr_opcode = 4'h0;
    instr_rd     = 3'd6;
    instr_ra     = 3'd5;
    instr_rb     = 3'd0;
    instr_valid  = 1'b1;
    result_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d valid", c), result_valid, 1);
      chk($sformatf("bp%0d data", c), result_data, 16'hABCD);
      chk($sformatf("bp%0d flags", c), result_flags, 3'b000);
      chk($sformatf("bp%0d ready", c), instr_ready, 0);
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    chk("bp release_valid", result_valid, 0);
    chk("bp release_ready", instr_ready, 1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("bp queued_accepted", instr_ready, 0);
    chk("bp queued_a", alu_in_a, 16'hABCD);
    chk("bp queued_b", alu_in_b, 16'h0000);
    @(posedge clk); #1;
    chk("bp queued_valid", result_valid, 1);
    chk("bp queued_data", result_data, 16'hABCD);
    chk("bp queued_flags", result_flags, 3'b010);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;

    // Reset while in RESP: result_valid drops at once.
    accept(1'b1, 4'h0, 3'd1, 3'd0, 3'd0, 16'h0005);
    @(posedge clk); #1;
    chk("rresp valid_before", result_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rresp valid_dropped", result_valid, 0);
    chk("rresp data_cleared", result_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rresp ready_back", instr_ready, 1);

    // Reset during EXEC of ADD r3: no writeback.
    do_vec(0);
    do_vec(1);
    accept(1'b0, 4'h0, 3'd3, 3'd1, 3'd2, 16'h0000);
    chk("rexec operand_a", alu_in_a, 16'h0002);
    rst_n = 1'b0;
    #1;
    chk("rexec valid", result_valid, 0);
    chk("rexec ready", instr_ready, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rexec valid_after", result_valid, 0);
    chk("rexec ready_after", instr_ready, 1);
    accept(1'b0, 4'h0, 3'd7, 3'd3, 3'd0, 16'h0000);
    chk("rexec r3_read", alu_in_a, 16'h0000);
    @(posedge clk); #1;
    chk("rexec r3_data", result_data, 16'h0000);
    chk("rexec r3_flags", result_flags, 3'b001);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequencing front-end for the combinational `alu`. Accepts register-to-register instructions over a valid/ready handshake and reads operands from a small internal register file. Drives the ALU operand/opcode ports, captures the ALU result and flags, and writes the result back. It returns each result to the requester over a second valid/ready handshake. It sits between the instruction source (bench or future decoder) and the `alu`, which stays a separate instance.

## Interface
- `BW`, 16, datapath width; must match the instantiated `alu`.
- `NREG`, 8, number of architectural registers; register index width is `$clog2(NREG)`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  block can accept an instruction.
- `instr_load`  in  1  1 = load immediate into `rd`; 0 = ALU operation.
- `instr_opcode`  in  4  ALU opcode (0000 ADD, 0001 SUB, others passed through unchanged).
- `instr_rd`, `instr_ra`, `instr_rb`  in  $clog2(NREG) each  destination and source register indices.
- `instr_imm`  in  BW  immediate for loads.
- `alu_in_a`, `alu_in_b`  out  BW  operands to `alu`.
- `alu_opcode`  out  4  opcode to `alu`.
- `alu_out`  in  BW  result from `alu`.
- `alu_flags`  in  3  {overflow, negative, zero} from `alu`.
- `result_valid`  out  1  result available.
- `result_ready`  in  1  requester accepts result.
- `result_data`  out  BW  written-back value.
- `result_flags`  out  3  flag register after the instruction.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - `instr_ready`=1.
  - On `instr_valid && instr_ready`, latch opcode, rd, load bit, and imm, plus operand values read from ra/rb (not the indices), then go to EXEC.
- EXEC:
  - Latched operands/opcode are driven onto the `alu_*` ports; the ALU settles combinationally.
  - At the end of EXEC:
    - ALU op: write `alu_out` to rd, `alu_flags` to the flag register, and `result_data`/`result_flags`.
    - Load: write imm to rd and to `result_data`; flag register unchanged; `result_flags` = current flag register.
  - Then go to RESP.
- RESP:
  - `result_valid`=1.
  - On `result_ready`, go to IDLE.
- Register r0 reads as 0; writes to r0 are discarded, but `result_data` still reports the computed value.
- rd == ra or rd == rb is legal: operands are latched before writeback.
- `instr_valid` is ignored outside IDLE. `result_ready` is ignored outside RESP.
- `alu_*` outputs hold their latched values in all states; they change only on a new accept.

## Timing
- Reset (async assert, sync-safe deassert):
  - State IDLE.
  - All registers, flag register, `result_data`, `result_flags`, and the `alu_in_a`/`alu_in_b`/`alu_opcode` latches reset to 0.
  - `result_valid`=0.
  - `instr_ready`=0 while `rst_n`=0; `instr_ready`=1 from the first edge after release.
- Latency: instruction accepted at edge k → `alu_*` valid after edge k → writeback and `result_valid`=1 after edge k+1.
- Throughput: with `result_ready` tied high, one instruction per 3 cycles; `instr_ready` returns to 1 after the edge where the result handshake completes.
- Backpressure: in RESP, `result_data`/`result_flags` are held stable until the handshake; `instr_ready`=0 throughout.
- Reset mid-EXEC or mid-RESP: no writeback occurs if the capture edge has not happened; `result_valid` drops immediately.

## Structure
- Shared package `alu_pkg`:
  - opcode enum (ADD=4'b0000, SUB=4'b0001);
  - flag bit indices (OVF=2, NEG=1, ZERO=0);
  - FSM state enum.
- One sub-module: `alu_regfile` (NREG×BW, two combinational read ports, one synchronous write port, r0 hard-zero, async active-low reset).
- `alu` is instantiated beside `alu_seq` by the integrating level.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → all outputs 0 and `instr_ready`=0; one edge after release → `instr_ready`=1.
- Add: LOAD r1=0x0002, LOAD r2=0x0002, ADD r3=r1+r2 → in EXEC `alu_in_a`=`alu_in_b`=0x0002 and `alu_opcode`=0000; `result_data`=0x0004, `result_flags`=000, 2 cycles after accept.
- Sub overflow: LOAD r1=0x7FFF, LOAD r2=0xFFFF, SUB r3=r1-r2 → `result_data`=0x8000, `result_flags`=110. Follow with LOAD r4=0x1234 → `result_flags` still 110.
- Zero and r0: SUB r5=r1-r1 → 0x0000, flags 001. Then ADD r0=r1+r1 → `result_data`=0xFFFE, and a following ADD r6=r0+r0 → 0x0000.
- Backpressure: `result_ready`=0 for 5 cycles while `instr_valid`=1 → `result_*` stable and `instr_ready`=0; release → IDLE next edge, queued instruction accepted the cycle after.
- Mid-op reset: assert `rst_n`=0 during EXEC of ADD r3 → after release r3 reads 0 and `result_valid`=0.
